// File: rtl/conv_checker.sv
// conv_checker: FastICA convergence test, worst row deviation of W against the previous W,
// with w and -w treated as the same row vector, plus a saturating iteration counter.
module conv_checker #(
  parameter int WIDTH    = 26,
  parameter int TOL      = 64,
  parameter int MAX_ITER = 256,
  parameter int ITER_W   = 9
)(
  input  logic                    clk_conv,
  input  logic                    rstn_conv,
  input  logic                    en_conv,
  input  logic                    iter_clr,
  input  logic signed [WIDTH-1:0] w_in11, w_in12, w_in13, w_in14,
  input  logic signed [WIDTH-1:0] w_in21, w_in22, w_in23, w_in24,
  input  logic signed [WIDTH-1:0] w_in31, w_in32, w_in33, w_in34,
  input  logic signed [WIDTH-1:0] w_in41, w_in42, w_in43, w_in44,
  output logic                    busy,
  output logic                    done,
  output logic                    converged,
  output logic                    max_iter_hit,
  output logic [ITER_W-1:0]       iter_cnt,
  output logic [WIDTH:0]          max_diff,
  output logic signed [WIDTH-1:0] w_out11, w_out12, w_out13, w_out14,
  output logic signed [WIDTH-1:0] w_out21, w_out22, w_out23, w_out24,
  output logic signed [WIDTH-1:0] w_out31, w_out32, w_out33, w_out34,
  output logic signed [WIDTH-1:0] w_out41, w_out42, w_out43, w_out44
);
  localparam logic [ITER_W-1:0] MAX_I = ITER_W'(MAX_ITER);
  localparam logic [WIDTH:0]    TOL_V = (WIDTH+1)'(TOL);
  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;
  state_t r_state, w_next;
  logic signed [WIDTH-1:0] w_in_a [16];
  logic signed [WIDTH-1:0] r_cur [16];
  logic signed [WIDTH-1:0] r_prev [16];
  logic signed [WIDTH-1:0] r_wout [16];
  logic [3:0] r_idx;
  logic [WIDTH:0] r_pos, r_neg, r_glob, r_max_diff;
  logic r_hist, r_busy, r_done, r_conv, r_mih;
  logic [ITER_W-1:0] r_iter, w_iter_n;
  logic signed [WIDTH:0] w_a, w_b, w_sub, w_add;
  logic [WIDTH:0] w_dm, w_dp, w_pos_n, w_neg_n, w_row, w_glob_n;
  assign w_in_a = '{w_in11, w_in12, w_in13, w_in14, w_in21, w_in22, w_in23, w_in24,
                    w_in31, w_in32, w_in33, w_in34, w_in41, w_in42, w_in43, w_in44};
  // one extra bit makes both sum and difference exact; |-2^WIDTH| still fits unsigned
  assign w_a      = (WIDTH+1)'(r_cur[r_idx]);
  assign w_b      = (WIDTH+1)'(r_prev[r_idx]);
  assign w_sub    = w_a - w_b;
  assign w_add    = w_a + w_b;
  assign w_dm     = w_sub[WIDTH] ? -w_sub : w_sub;
  assign w_dp     = w_add[WIDTH] ? -w_add : w_add;
  assign w_pos_n  = w_dm > r_pos ? w_dm : r_pos;
  assign w_neg_n  = w_dp > r_neg ? w_dp : r_neg;
  assign w_row    = w_pos_n < w_neg_n ? w_pos_n : w_neg_n;
  assign w_glob_n = w_row > r_glob ? w_row : r_glob;
  assign w_iter_n = r_iter == MAX_I ? r_iter : r_iter + 1'b1;
  always_ff @(posedge clk_conv or negedge rstn_conv)
    if (!rstn_conv) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (iter_clr) w_next = IDLE;
    else
      case (r_state)
        IDLE:    w_next = en_conv ? (r_hist ? SCAN : DECIDE) : IDLE;
        SCAN:    w_next = r_idx == 4'd15 ? DECIDE : SCAN;
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk_conv or negedge rstn_conv)
    if (!rstn_conv) begin
      for (int i = 0; i < 16; i++) begin
        r_cur[i]  <= '0;
        r_prev[i] <= '0;
        r_wout[i] <= '0;
      end
      r_idx      <= '0;
      r_pos      <= '0;
      r_neg      <= '0;
      r_glob     <= '0;
      r_max_diff <= '0;
      r_hist     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_conv     <= 1'b0;
      r_mih      <= 1'b0;
      r_iter     <= '0;
    end else begin
      r_done <= 1'b0;
      if (iter_clr) begin
        r_busy <= 1'b0;
        r_hist <= 1'b0;
        r_iter <= '0;
        r_conv <= 1'b0;
        r_mih  <= 1'b0;
      end else
        case (r_state)
          IDLE: if (en_conv) begin
            r_cur  <= w_in_a;
            r_busy <= 1'b1;
            r_idx  <= '0;
            r_pos  <= '0;
            r_neg  <= '0;
            r_glob <= '0;
          end
          SCAN: begin
            r_idx <= r_idx + 1'b1;
            r_pos <= r_idx[1:0] == 2'd3 ? '0 : w_pos_n;
            r_neg <= r_idx[1:0] == 2'd3 ? '0 : w_neg_n;
            if (r_idx[1:0] == 2'd3) r_glob <= w_glob_n;
          end
          default: begin
            r_max_diff <= r_hist ? r_glob : '0;
            r_conv     <= r_hist && (r_glob <= TOL_V);
            r_prev     <= r_cur;
            r_wout     <= r_cur;
            r_hist     <= 1'b1;
            r_iter     <= w_iter_n;
            r_mih      <= w_iter_n == MAX_I;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
          end
        endcase
    end
  assign busy         = r_busy;
  assign done         = r_done;
  assign converged    = r_conv;
  assign max_iter_hit = r_mih;
  assign iter_cnt     = r_iter;
  assign max_diff     = r_max_diff;
  assign w_out11 = r_wout[0];
  assign w_out12 = r_wout[1];
  assign w_out13 = r_wout[2];
  assign w_out14 = r_wout[3];
  assign w_out21 = r_wout[4];
  assign w_out22 = r_wout[5];
  assign w_out23 = r_wout[6];
  assign w_out24 = r_wout[7];
  assign w_out31 = r_wout[8];
  assign w_out32 = r_wout[9];
  assign w_out33 = r_wout[10];
  assign w_out34 = r_wout[11];
  assign w_out41 = r_wout[12];
  assign w_out42 = r_wout[13];
  assign w_out43 = r_wout[14];
  assign w_out44 = r_wout[15];
endmodule

// File: tb/tb_conv_checker.sv
// tb_conv_checker: directed iterations checked every cycle against a row-level model plus literal expectations.
module tb_conv_checker;
  localparam int W = 26;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic en_conv = 1'b0;
  logic iter_clr = 1'b0;
  logic signed [W-1:0] w_in [16];
  wire signed [W-1:0] w_out [16];
  logic busy, done, converged, max_iter_hit;
  logic [8:0] iter_cnt;
  logic [W:0] max_diff;
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  conv_checker #(.WIDTH(W), .TOL(64), .MAX_ITER(4), .ITER_W(9)) dut (
    .clk_conv(clk), .rstn_conv(rstn), .en_conv(en_conv), .iter_clr(iter_clr),
    .w_in11(w_in[0]), .w_in12(w_in[1]), .w_in13(w_in[2]), .w_in14(w_in[3]),
    .w_in21(w_in[4]), .w_in22(w_in[5]), .w_in23(w_in[6]), .w_in24(w_in[7]),
    .w_in31(w_in[8]), .w_in32(w_in[9]), .w_in33(w_in[10]), .w_in34(w_in[11]),
    .w_in41(w_in[12]), .w_in42(w_in[13]), .w_in43(w_in[14]), .w_in44(w_in[15]),
    .busy(busy), .done(done), .converged(converged), .max_iter_hit(max_iter_hit),
    .iter_cnt(iter_cnt), .max_diff(max_diff),
    .w_out11(w_out[0]), .w_out12(w_out[1]), .w_out13(w_out[2]), .w_out14(w_out[3]),
    .w_out21(w_out[4]), .w_out22(w_out[5]), .w_out23(w_out[6]), .w_out24(w_out[7]),
    .w_out31(w_out[8]), .w_out32(w_out[9]), .w_out33(w_out[10]), .w_out34(w_out[11]),
    .w_out41(w_out[12]), .w_out42(w_out[13]), .w_out43(w_out[14]), .w_out44(w_out[15])
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  function automatic longint absl(input longint x);
    return x < 0 ? -x : x;
  endfunction
  longint m_cur [16];
  longint m_prev [16];
  longint m_wout [16];
  longint m_res = 0, m_diff = 0, pm, nm, rd;
  int m_left = 0, m_iter = 0;
  bit m_hist = 0, m_conv = 0, m_mih = 0, m_done = 0;
  // model: the result is known at capture; only its publication waits out the latency
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      m_left = 0; m_iter = 0; m_hist = 0; m_conv = 0; m_mih = 0; m_done = 0; m_diff = 0;
      for (int k = 0; k < 16; k++) begin m_prev[k] = 0; m_wout[k] = 0; end
    end else begin
      m_done = 0;
      if (iter_clr) begin
        m_left = 0; m_hist = 0; m_iter = 0; m_conv = 0; m_mih = 0;
      end else if (m_left == 0 && en_conv) begin
        for (int k = 0; k < 16; k++) m_cur[k] = w_in[k];
        m_res = 0;
        for (int r = 0; r < 4; r++) begin
          pm = 0; nm = 0;
          for (int j = 0; j < 4; j++) begin
            if (absl(m_cur[4*r+j] - m_prev[4*r+j]) > pm) pm = absl(m_cur[4*r+j] - m_prev[4*r+j]);
            if (absl(m_cur[4*r+j] + m_prev[4*r+j]) > nm) nm = absl(m_cur[4*r+j] + m_prev[4*r+j]);
          end
          rd = pm < nm ? pm : nm;
          if (rd > m_res) m_res = rd;
        end
        m_left = m_hist ? 17 : 1;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_diff = m_hist ? m_res : 0;
          m_conv = m_hist && m_res <= 64;
          m_iter = m_iter == 4 ? 4 : m_iter + 1;
          m_mih = m_iter == 4;
          m_hist = 1;
          m_done = 1;
          for (int k = 0; k < 16; k++) begin m_prev[k] = m_cur[k]; m_wout[k] = m_cur[k]; end
        end
      end
    end
  always @(negedge clk)
    if (chk_en && rstn) begin
      chk("busy", longint'(busy), longint'(m_left > 0));
      chk("done", longint'(done), longint'(m_done));
      chk("converged", longint'(converged), longint'(m_conv));
      chk("max_iter_hit", longint'(max_iter_hit), longint'(m_mih));
      chk("iter_cnt", longint'(iter_cnt), longint'(m_iter));
      chk("max_diff", longint'(max_diff), m_diff);
      for (int k = 0; k < 16; k++) chk($sformatf("w_out[%0d]", k), longint'(w_out[k]), m_wout[k]);
    end
  task automatic diag();
    for (int k = 0; k < 16; k++) w_in[k] = (k % 5 == 0) ? 26'sd8192 : 26'sd0;
  endtask
  task automatic pulse_en();
    @(posedge clk); #1 en_conv = 1'b1;
    @(posedge clk); #1 en_conv = 1'b0;
  endtask
  task automatic run(input int lat_e, input longint diff_e, input bit conv_e, input int iter_e, input bit mih_e, input bit dbl);
    int n, extra;
    bit got;
    pulse_en();
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (dbl && n == 4) en_conv = 1'b1;
      if (dbl && n == 5) en_conv = 1'b0;
      got = done;
    end
    chk("latency", n, lat_e);
    chk("lit_max_diff", longint'(max_diff), diff_e);
    chk("lit_converged", longint'(converged), longint'(conv_e));
    chk("lit_iter_cnt", longint'(iter_cnt), iter_e);
    chk("lit_max_iter_hit", longint'(max_iter_hit), longint'(mih_e));
    extra = 0;
    repeat (20) begin @(negedge clk); if (done) extra++; end
    chk("extra_done", extra, 0);
  endtask
  initial begin
    int n;
    diag();
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_iter_cnt", longint'(iter_cnt), 0);
    chk("rst_max_diff", longint'(max_diff), 0);
    chk("rst_w_out11", longint'(w_out[0]), 0);
    run(2, 0, 0, 1, 0, 0);
    chk("first_w_out11", longint'(w_out[0]), 8192);
    chk("first_w_out12", longint'(w_out[1]), 0);
    run(18, 0, 1, 2, 0, 1);
    diag(); w_in[10] = -26'sd8192;
    run(18, 0, 1, 3, 0, 0);
    for (int k = 0; k < 16; k++) w_in[k] = '0;
    w_in[0] = 26'sd33554431;
    run(18, 33546239, 0, 4, 1, 0);
    w_in[0] = -26'sd33554432;
    run(18, 1, 1, 4, 1, 0);
    @(posedge clk); #1 iter_clr = 1'b1;
    @(posedge clk); #1 iter_clr = 1'b0;
    chk("clr_iter_cnt", longint'(iter_cnt), 0);
    chk("clr_max_iter_hit", longint'(max_iter_hit), 0);
    chk("clr_converged", longint'(converged), 0);
    diag();
    run(2, 0, 0, 1, 0, 0);
    w_in[7] = 26'sd65;
    run(18, 65, 0, 2, 0, 0);
    diag();
    run(18, 65, 0, 3, 0, 0);
    w_in[7] = 26'sd64;
    run(18, 64, 1, 4, 1, 0);
    diag();
    pulse_en();
    n = 0;
    repeat (4) begin @(negedge clk); n += int'(done); end
    iter_clr = 1'b1;
    @(negedge clk); n += int'(done);
    iter_clr = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    repeat (25) begin @(negedge clk); n += int'(done); end
    chk("abort_no_done", n, 0);
    chk("abort_iter_cnt", longint'(iter_cnt), 0);
    chk("abort_max_diff", longint'(max_diff), 64);
    chk("abort_w_out24", longint'(w_out[7]), 64);
    run(2, 0, 0, 1, 0, 0);
    run(18, 0, 1, 2, 0, 0);
    pulse_en();
    repeat (6) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("arst_busy", longint'(busy), 0);
    chk("arst_iter_cnt", longint'(iter_cnt), 0);
    chk("arst_converged", longint'(converged), 0);
    chk("arst_w_out11", longint'(w_out[0]), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    run(2, 0, 0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
